// File: rtl/sobel_pkg.sv
// ----------------------------------------------------------------------------
// sobel_pkg
//   Shared types and constants for the Sobel line-buffer stage and its
//   neighbours (convolution, output writer).
//   - PIX_W            : grayscale pixel width
//   - DEF_IMG_HEIGHT   : default rows per frame
//   - DEF_IMG_WIDTH    : default pixels per row
//   - line_state_t     : line scheduler state
//   - column_t         : one 3-pixel column (rows r-2, r-1, r)
// ----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W          = 8;
    localparam int DEF_IMG_HEIGHT = 720;
    localparam int DEF_IMG_WIDTH  = 540;

    typedef enum logic [1:0] {FILL0, FILL1, STREAM, DRAIN} line_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } column_t;

endpackage

// File: rtl/raster_counter.sv
// ----------------------------------------------------------------------------
// raster_counter
//   Row/column position counter for a raster scan. The column advances on
//   every i_step and wraps COLS-1 -> 0, at which point the row advances and
//   itself wraps ROWS-1 -> 0. i_clr returns both to 0 and wins over i_step.
//
//   Ports:
//     clock, reset  : clock, asynchronous active-high reset
//     i_clr         : synchronous clear of row and column
//     i_step        : advance one position
//     o_row, o_col  : current position
//     o_col_last    : column is COLS-1 (next step wraps the row)
//     o_last_pix    : position is (ROWS-1, COLS-1)
// ----------------------------------------------------------------------------
module raster_counter
    import sobel_pkg::*;
#(
    parameter  int ROWS = DEF_IMG_HEIGHT,
    parameter  int COLS = DEF_IMG_WIDTH,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_step,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_col_last,
    output logic          o_last_pix
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_row_last;

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_col_last = (r_col == CW'(COLS - 1));
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign o_last_pix = o_col_last && w_row_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (o_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_line_ctrl.sv
// ----------------------------------------------------------------------------
// sobel_line_ctrl
//   Line-buffer scheduler for the Sobel stage. Pixels arrive in raster order
//   from a first-word-fall-through input FIFO and are rotated through two
//   external row FIFOs: line1 holds row r-1, line0 holds row r-2. Every
//   accepted pixel yields one registered 3-pixel column plus a shift strobe
//   for the downstream 3x3 window. After the last pixel of a frame both row
//   FIFOs are drained so the next frame starts from empty buffers.
//
//   Ports:
//     clock, reset              : clock, asynchronous active-high reset
//     in_empty/in_rd_en/in_dout : input pixel FIFO (FWFT)
//     l0_* / l1_*               : line0 / line1 row FIFOs (FWFT read side,
//                                 write side driven from here)
//     stall                     : downstream back-pressure
//     col_shift                 : col_top/mid/bot valid this cycle
//     col_top/col_mid/col_bot   : pixels from rows r-2, r-1, r
//     win_valid                 : with col_shift, window centred at
//                                 (win_row, win_col) is complete
//     frame_done                : one-cycle pulse after the drain completes
// ----------------------------------------------------------------------------
module sobel_line_ctrl
    import sobel_pkg::*;
#(
    parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
    localparam int RW         = $clog2(IMG_HEIGHT),
    localparam int CW         = $clog2(IMG_WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    // input pixel FIFO
    input  logic             in_empty,
    output logic             in_rd_en,
    input  logic [PIX_W-1:0] in_dout,
    // line0 FIFO (row r-2)
    input  logic             l0_empty,
    output logic             l0_rd_en,
    input  logic [PIX_W-1:0] l0_dout,
    input  logic             l0_full,
    output logic             l0_wr_en,
    output logic [PIX_W-1:0] l0_din,
    // line1 FIFO (row r-1)
    input  logic             l1_empty,
    output logic             l1_rd_en,
    input  logic [PIX_W-1:0] l1_dout,
    input  logic             l1_full,
    output logic             l1_wr_en,
    output logic [PIX_W-1:0] l1_din,
    // downstream
    input  logic             stall,
    output logic             col_shift,
    output logic [PIX_W-1:0] col_top,
    output logic [PIX_W-1:0] col_mid,
    output logic [PIX_W-1:0] col_bot,
    output logic             win_valid,
    output logic [RW-1:0]    win_row,
    output logic [CW-1:0]    win_col,
    output logic             frame_done
);

    line_state_t   r_state;
    column_t       r_col;
    logic          r_col_shift;
    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_frame_done;

    logic          w_in_ok;
    logic          w_step;
    logic          w_drain_pop;
    logic          w_drain_last;
    column_t       w_col_next;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_col_last;
    logic          w_last_pix;

    // ------------------------------------------------------------------
    // Step qualification. Each state only needs the FIFOs it touches;
    // in STREAM every line push is paired with a pop, so full never matters.
    // Reset gates everything so no FIFO moves while the block is held.
    // ------------------------------------------------------------------
    assign w_in_ok = !in_empty && !stall;

    always_comb begin
        w_step      = 1'b0;
        w_drain_pop = 1'b0;
        case (r_state)
            FILL0:   w_step      = w_in_ok && !l1_full;
            FILL1:   w_step      = w_in_ok && !l1_empty && !l0_full;
            STREAM:  w_step      = w_in_ok && !l0_empty && !l1_empty;
            DRAIN:   w_drain_pop = !l0_empty && !l1_empty;
            default: ;
        endcase
        if (reset) begin
            w_step      = 1'b0;
            w_drain_pop = 1'b0;
        end
    end

    // line1 always takes the new pixel; line0 takes what line1 gives up.
    assign in_rd_en = w_step;
    assign l1_wr_en = w_step;
    assign l1_din   = in_dout;
    assign l0_wr_en = w_step && (r_state != FILL0);
    assign l0_din   = l1_dout;
    assign l1_rd_en = (w_step && (r_state != FILL0)) || w_drain_pop;
    assign l0_rd_en = (w_step && (r_state == STREAM)) || w_drain_pop;

    // Rows that do not exist yet (above the frame) read as zero.
    always_comb begin
        w_col_next.top = '0;
        w_col_next.mid = '0;
        w_col_next.bot = in_dout;
        case (r_state)
            FILL1: begin
                w_col_next.mid = l1_dout;
            end
            STREAM: begin
                w_col_next.top = l0_dout;
                w_col_next.mid = l1_dout;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Position counter. In DRAIN the column field counts drain pops; the
    // wrap on the last pop would bump the row, so that step clears instead.
    // ------------------------------------------------------------------
    assign w_drain_last = w_drain_pop && w_col_last;

    raster_counter #(
        .ROWS (IMG_HEIGHT),
        .COLS (IMG_WIDTH)
    ) u_pos (
        .clock      (clock),
        .reset      (reset),
        .i_clr      (w_drain_last),
        .i_step     (w_step || w_drain_pop),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_col_last (w_col_last),
        .o_last_pix (w_last_pix)
    );

    // ------------------------------------------------------------------
    // State machine and registered column outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= FILL0;
            r_col        <= '0;
            r_col_shift  <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_col_shift  <= w_step;
            r_win_valid  <= w_step && (r_state == STREAM) && (w_col >= CW'(2));
            r_frame_done <= w_drain_last;

            if (w_step) begin
                r_col     <= w_col_next;
                // window centre trails the incoming pixel by one row and col
                r_win_row <= w_row - RW'(1);
                r_win_col <= w_col - CW'(1);
            end

            case (r_state)
                FILL0:   if (w_step && w_col_last)  r_state <= FILL1;
                FILL1:   if (w_step && w_col_last)  r_state <= STREAM;
                STREAM:  if (w_step && w_last_pix)  r_state <= DRAIN;
                DRAIN:   if (w_drain_last)          r_state <= FILL0;
                default:                            r_state <= FILL0;
            endcase
        end
    end

    assign col_shift  = r_col_shift;
    assign col_top    = r_col.top;
    assign col_mid    = r_col.mid;
    assign col_bot    = r_col.bot;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_line_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sobel_line_ctrl
//   Two instances: 4x4 (index 0) and 3x3 (index 1). Only one is active at a
//   time; the bench models the input FIFO and both row FIFOs with queues and
//   predicts every column from the frame image directly.
// ----------------------------------------------------------------------------
module tb_sobel_line_ctrl;

    localparam int NI = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       in_empty [NI];
    logic       in_rd_en [NI];
    logic [7:0] in_dout  [NI];
    logic       l0_empty [NI];
    logic       l0_rd_en [NI];
    logic [7:0] l0_dout  [NI];
    logic       l0_full  [NI];
    logic       l0_wr_en [NI];
    logic [7:0] l0_din   [NI];
    logic       l1_empty [NI];
    logic       l1_rd_en [NI];
    logic [7:0] l1_dout  [NI];
    logic       l1_full  [NI];
    logic       l1_wr_en [NI];
    logic [7:0] l1_din   [NI];
    logic       stall    [NI];
    logic       col_shift[NI];
    logic [7:0] col_top  [NI];
    logic [7:0] col_mid  [NI];
    logic [7:0] col_bot  [NI];
    logic       win_valid[NI];
    logic [1:0] win_row  [NI];
    logic [1:0] win_col  [NI];
    logic       frame_done[NI];

    sobel_line_ctrl #(.IMG_HEIGHT(4), .IMG_WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_empty(in_empty[0]), .in_rd_en(in_rd_en[0]), .in_dout(in_dout[0]),
        .l0_empty(l0_empty[0]), .l0_rd_en(l0_rd_en[0]), .l0_dout(l0_dout[0]),
        .l0_full(l0_full[0]), .l0_wr_en(l0_wr_en[0]), .l0_din(l0_din[0]),
        .l1_empty(l1_empty[0]), .l1_rd_en(l1_rd_en[0]), .l1_dout(l1_dout[0]),
        .l1_full(l1_full[0]), .l1_wr_en(l1_wr_en[0]), .l1_din(l1_din[0]),
        .stall(stall[0]), .col_shift(col_shift[0]),
        .col_top(col_top[0]), .col_mid(col_mid[0]), .col_bot(col_bot[0]),
        .win_valid(win_valid[0]), .win_row(win_row[0]), .win_col(win_col[0]),
        .frame_done(frame_done[0])
    );

    sobel_line_ctrl #(.IMG_HEIGHT(3), .IMG_WIDTH(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .in_empty(in_empty[1]), .in_rd_en(in_rd_en[1]), .in_dout(in_dout[1]),
        .l0_empty(l0_empty[1]), .l0_rd_en(l0_rd_en[1]), .l0_dout(l0_dout[1]),
        .l0_full(l0_full[1]), .l0_wr_en(l0_wr_en[1]), .l0_din(l0_din[1]),
        .l1_empty(l1_empty[1]), .l1_rd_en(l1_rd_en[1]), .l1_dout(l1_dout[1]),
        .l1_full(l1_full[1]), .l1_wr_en(l1_wr_en[1]), .l1_din(l1_din[1]),
        .stall(stall[1]), .col_shift(col_shift[1]),
        .col_top(col_top[1]), .col_mid(col_mid[1]), .col_bot(col_bot[1]),
        .win_valid(win_valid[1]), .win_row(win_row[1]), .win_col(win_col[1]),
        .frame_done(frame_done[1])
    );

    typedef struct {
        int t, m, b, wv, wr, wc;
    } exp_t;

    logic [7:0] qin[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       expq[$];

    int cur, H, W;
    int total, bad;
    int frames_done, strobes, wins, acc;
    bit prev_stall;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: a column is the pixel plus the two pixels above it in the
    // same column (zero above the frame); a window is complete once the
    // pixel is at least two rows and two columns into the frame.
    task automatic load_frame(input int base, input bit rnd);
        int img[4][4];
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c] = rnd ? int'($urandom_range(0, 255)) : (base + r * W + c) & 255;
                qin.push_back(8'(img[r][c]));
            end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e.t  = (r >= 2) ? img[r-2][c] : 0;
                e.m  = (r >= 1) ? img[r-1][c] : 0;
                e.b  = img[r][c];
                e.wv = (r >= 2 && c >= 2) ? 1 : 0;
                e.wr = r - 1;
                e.wc = c - 1;
                expq.push_back(e);
            end
    endtask

    task automatic drive(input bit st, input bit gap);
        for (int k = 0; k < NI; k++) begin
            if (k == cur) begin
                in_empty[k] = gap || (qin.size() == 0);
                in_dout[k]  = (qin.size() != 0) ? qin[0] : 8'h00;
                l0_empty[k] = (q0.size() == 0);
                l0_dout[k]  = (q0.size() != 0) ? q0[0] : 8'h00;
                l0_full[k]  = (q0.size() >= W);
                l1_empty[k] = (q1.size() == 0);
                l1_dout[k]  = (q1.size() != 0) ? q1[0] : 8'h00;
                l1_full[k]  = (q1.size() >= W);
                stall[k]    = st;
            end else begin
                in_empty[k] = 1'b1; in_dout[k] = 8'h00;
                l0_empty[k] = 1'b1; l0_dout[k] = 8'h00; l0_full[k] = 1'b0;
                l1_empty[k] = 1'b1; l1_dout[k] = 8'h00; l1_full[k] = 1'b0;
                stall[k]    = 1'b0;
            end
        end
    endtask

    task automatic chk_idle(input int k);
        chk("rst_col_shift", col_shift[k], 0);
        chk("rst_win_valid", win_valid[k], 0);
        chk("rst_frame_done", frame_done[k], 0);
        chk("rst_col_top", col_top[k], 0);
        chk("rst_col_mid", col_mid[k], 0);
        chk("rst_col_bot", col_bot[k], 0);
        chk("rst_win_row", win_row[k], 0);
        chk("rst_win_col", win_col[k], 0);
        chk("rst_in_rd", in_rd_en[k], 0);
        chk("rst_l0_rd", l0_rd_en[k], 0);
        chk("rst_l1_rd", l1_rd_en[k], 0);
        chk("rst_l0_wr", l0_wr_en[k], 0);
        chk("rst_l1_wr", l1_wr_en[k], 0);
    endtask

    task automatic check_out();
        exp_t e;
        if (prev_stall) chk("shift_after_stall", col_shift[cur], 0);
        if (col_shift[cur]) begin
            if (expq.size() == 0) begin
                chk("extra_shift", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("col_top", col_top[cur], e.t);
                chk("col_mid", col_mid[cur], e.m);
                chk("col_bot", col_bot[cur], e.b);
                chk("win_valid", win_valid[cur], e.wv);
                if (e.wv != 0) begin
                    chk("win_row", win_row[cur], e.wr);
                    chk("win_col", win_col[cur], e.wc);
                end
                strobes++;
                wins += e.wv;
            end
        end else begin
            chk("win_without_shift", win_valid[cur], 0);
        end
        if (frame_done[cur]) begin
            chk("drain_l0_empty", q0.size(), 0);
            chk("drain_l1_empty", q1.size(), 0);
            chk("frame_strobes", strobes, H * W);
            chk("frame_wins", wins, (H - 2) * (W - 2));
            strobes = 0;
            wins    = 0;
            frames_done++;
        end
    endtask

    // One clock: drive at negedge, check and sample enables just after,
    // then apply FIFO moves at the posedge.
    task automatic cycle(input bit st, input bit gap);
        bit rin, r0, r1, w0, w1;
        logic [7:0] d0, d1;
        @(negedge clock);
        drive(st, gap);
        #1;
        check_out();
        if (st || in_empty[cur]) chk("no_pop_when_blocked", in_rd_en[cur], 0);
        rin = in_rd_en[cur]; r0 = l0_rd_en[cur]; r1 = l1_rd_en[cur];
        w0 = l0_wr_en[cur]; w1 = l1_wr_en[cur];
        d0 = l0_din[cur];   d1 = l1_din[cur];
        @(posedge clock);
        if (rin) begin
            if (qin.size() == 0) chk("pop_empty_in", 1, 0);
            else begin void'(qin.pop_front()); acc++; end
        end
        if (r0) begin
            if (q0.size() == 0) chk("pop_empty_l0", 1, 0);
            else void'(q0.pop_front());
        end
        if (r1) begin
            if (q1.size() == 0) chk("pop_empty_l1", 1, 0);
            else void'(q1.pop_front());
        end
        if (w0) begin
            if (q0.size() >= W) chk("overflow_l0", 1, 0);
            q0.push_back(d0);
        end
        if (w1) begin
            if (q1.size() >= W) chk("overflow_l1", 1, 0);
            q1.push_back(d1);
        end
        prev_stall = st;
    endtask

    // mode 0: free run, 1: 3-cycle stall at pixel (2,1), 2: input empty
    // every other cycle, 3: random stall and empty.
    task automatic run(input int mode, input int target, input int budget);
        int done0 = frames_done;
        int stall_left = 3;
        bit st, gap;
        acc = 0;
        for (int n = 0; n < budget && frames_done < done0 + target; n++) begin
            st = 1'b0; gap = 1'b0;
            case (mode)
                1: if (acc == 9 && stall_left > 0) begin st = 1'b1; stall_left--; end
                2: gap = (n % 2) == 1;
                3: begin
                    st  = ($urandom_range(0, 3) == 0);
                    gap = ($urandom_range(0, 2) == 0);
                end
                default: ;
            endcase
            cycle(st, gap);
        end
        chk("frames_in_budget", frames_done - done0, target);
        chk("expected_left", expq.size(), 0);
        if (mode == 1) chk("stall_cycles_used", stall_left, 0);
    endtask

    initial begin
        total = 0; bad = 0; frames_done = 0; strobes = 0; wins = 0; acc = 0;
        prev_stall = 1'b0;
        cur = 0; H = 4; W = 4;
        reset = 1'b1;
        drive(1'b0, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        for (int k = 0; k < NI; k++) chk_idle(k);
        @(negedge clock);
        reset = 1'b0;

        // 4x4, ramp 0..15
        load_frame(0, 1'b0);
        run(0, 1, 400);
        // stall held three cycles in row 2
        load_frame(0, 1'b0);
        run(1, 1, 400);
        // input FIFO empty every other cycle
        load_frame(0, 1'b0);
        run(2, 1, 400);
        // back-to-back frames, second starts at 100
        load_frame(0, 1'b0);
        load_frame(100, 1'b0);
        run(0, 2, 800);
        // random pixels, random stall/empty
        load_frame(0, 1'b1);
        load_frame(0, 1'b1);
        run(3, 2, 2000);

        // reset while streaming pixel (2,1)
        load_frame(0, 1'b0);
        acc = 0;
        for (int n = 0; n < 100 && acc < 9; n++) cycle(1'b0, 1'b0);
        chk("reached_pixel_2_1", acc, 9);
        @(negedge clock);
        drive(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_idle(cur);
        @(posedge clock);
        qin.delete(); q0.delete(); q1.delete(); expq.delete();
        strobes = 0; wins = 0; prev_stall = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b0);
        reset = 1'b0;
        load_frame(50, 1'b0);
        run(0, 1, 400);

        // 3x3 minimum frame, 1..9
        cur = 1; H = 3; W = 3;
        load_frame(1, 1'b0);
        run(0, 1, 200);
        load_frame(0, 1'b1);
        run(3, 1, 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
